// File: rtl/venus_soc_pkg.sv
// Shared AXI channel bundles, arbitration mode encoding and arbiter FSM states.
package venus_soc_pkg;

  typedef struct packed {
    logic        aw_valid;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic        w_valid;
    logic [31:0] w_data;
    logic        w_last;
    logic        b_ready;
    logic        ar_valid;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic        r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic        b_valid;
    logic [1:0]  b_resp;
    logic        ar_ready;
    logic        r_valid;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
  } axi_resp_t;

  typedef enum logic [1:0] {
    ARB_RR    = 2'b00,
    ARB_DMA   = 2'b01,
    ARB_BFM   = 2'b10,
    ARB_FIXED = 2'b11
  } arb_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GNT_DMA = 2'b01,
    ST_GNT_BFM = 2'b10
  } arb_state_e;

endpackage

// File: rtl/axi_txn_counter.sv
// Saturating outstanding-transaction counter; simultaneous inc and dec cancel out.
module axi_txn_counter #(
  parameter int MaxTxns = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic dec,
  output logic at_max,
  output logic zero
);

  localparam int CntW = $clog2(MaxTxns + 1);

  logic [CntW-1:0] cnt_q;

  assign at_max = (cnt_q == CntW'(MaxTxns));
  assign zero   = (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc && !dec && !at_max) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (dec && !inc && !zero) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/axi_master_arbiter.sv
// Two-master (DMA, BFM) AXI arbiter: grant is held until every outstanding burst
// has completed and the owner has no pending valids.
//
// state      | meaning
// ST_IDLE    | no owner; choose next owner from arb mode and requests
// ST_GNT_DMA | DMA owns the slave port
// ST_GNT_BFM | BFM owns the slave port
module axi_master_arbiter
  import venus_soc_pkg::*;
#(
  parameter int MaxTxns = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] arb_mode_i,
  input  axi_req_t   axi_req_i_dma,
  input  axi_req_t   axi_req_i_bfm,
  input  axi_resp_t  axi_resp_i,
  output axi_req_t   axi_req_o,
  output axi_resp_t  axi_resp_o_dma,
  output axi_resp_t  axi_resp_o_bfm,
  output logic [1:0] grant_o,
  output logic       busy_o
);

  arb_state_e state_q, state_d;
  logic       last_bfm_q;
  logic       dma_req, bfm_req, pick_dma, pick_bfm;
  logic       owner_idle, cnt_zero;
  logic       aw_at_max, aw_zero, w_at_max, w_zero, ar_at_max, ar_zero;
  logic       aw_hs, b_hs, w_last_hs, ar_hs, r_last_hs;
  axi_req_t   owner_req;
  axi_resp_t  fwd_resp;

  assign dma_req = axi_req_i_dma.aw_valid | axi_req_i_dma.w_valid | axi_req_i_dma.ar_valid;
  assign bfm_req = axi_req_i_bfm.aw_valid | axi_req_i_bfm.w_valid | axi_req_i_bfm.ar_valid;

  // Round-robin ties go to whichever master did not own the port last.
  always_comb begin
    pick_dma = 1'b0;
    pick_bfm = 1'b0;
    case (arb_mode_e'(arb_mode_i))
      ARB_DMA:   pick_dma = dma_req;
      ARB_BFM:   pick_bfm = bfm_req;
      ARB_FIXED: begin
        pick_dma = dma_req;
        pick_bfm = bfm_req & ~dma_req;
      end
      default: begin
        if (dma_req && bfm_req) begin
          pick_dma = last_bfm_q;
          pick_bfm = ~last_bfm_q;
        end else begin
          pick_dma = dma_req;
          pick_bfm = bfm_req;
        end
      end
    endcase
  end

  assign owner_req  = (state_q == ST_GNT_BFM) ? axi_req_i_bfm : axi_req_i_dma;
  assign owner_idle = ~(owner_req.aw_valid | owner_req.w_valid | owner_req.ar_valid);
  assign cnt_zero   = aw_zero & w_zero & ar_zero;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_dma)      state_d = ST_GNT_DMA;
        else if (pick_bfm) state_d = ST_GNT_BFM;
      end
      ST_GNT_DMA, ST_GNT_BFM: begin
        if (cnt_zero && owner_idle) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      last_bfm_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q != ST_IDLE && state_d == ST_IDLE) begin
        last_bfm_q <= (state_q == ST_GNT_BFM);
      end
    end
  end

  always_comb begin
    fwd_resp          = axi_resp_i;
    fwd_resp.aw_ready = axi_resp_i.aw_ready & ~aw_at_max;
    fwd_resp.ar_ready = axi_resp_i.ar_ready & ~ar_at_max;
    axi_req_o         = '0;
    axi_resp_o_dma    = '0;
    axi_resp_o_bfm    = '0;
    if (state_q == ST_GNT_DMA) begin
      axi_req_o      = axi_req_i_dma;
      axi_resp_o_dma = fwd_resp;
    end else if (state_q == ST_GNT_BFM) begin
      axi_req_o      = axi_req_i_bfm;
      axi_resp_o_bfm = fwd_resp;
    end
    axi_req_o.aw_valid = axi_req_o.aw_valid & ~aw_at_max;
    axi_req_o.ar_valid = axi_req_o.ar_valid & ~ar_at_max;
  end

  assign aw_hs     = axi_req_o.aw_valid & axi_resp_i.aw_ready;
  assign b_hs      = axi_resp_i.b_valid & axi_req_o.b_ready;
  assign w_last_hs = axi_req_o.w_valid & axi_req_o.w_last & axi_resp_i.w_ready;
  assign ar_hs     = axi_req_o.ar_valid & axi_resp_i.ar_ready;
  assign r_last_hs = axi_resp_i.r_valid & axi_resp_i.r_last & axi_req_o.r_ready;

  axi_txn_counter #(.MaxTxns(MaxTxns)) u_aw_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc(aw_hs), .dec(b_hs), .at_max(aw_at_max), .zero(aw_zero)
  );

  axi_txn_counter #(.MaxTxns(MaxTxns)) u_w_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc(aw_hs), .dec(w_last_hs), .at_max(w_at_max), .zero(w_zero)
  );

  axi_txn_counter #(.MaxTxns(MaxTxns)) u_ar_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc(ar_hs), .dec(r_last_hs), .at_max(ar_at_max), .zero(ar_zero)
  );

  assign grant_o = {state_q == ST_GNT_BFM, state_q == ST_GNT_DMA};
  assign busy_o  = ~cnt_zero;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Self-checking bench for axi_master_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of ownership and outstanding bursts.
module tb_axi_master_arbiter;
  import venus_soc_pkg::*;

  localparam int MAX = 8;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] arb_mode_i;
  axi_req_t   dma, bfm, req_o;
  axi_resp_t  resp_i, resp_dma, resp_bfm;
  logic [1:0] grant_o;
  logic       busy_o;

  int checks = 0;
  int failures = 0;

  axi_master_arbiter #(.MaxTxns(MAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .arb_mode_i(arb_mode_i),
    .axi_req_i_dma(dma), .axi_req_i_bfm(bfm), .axi_resp_i(resp_i),
    .axi_req_o(req_o), .axi_resp_o_dma(resp_dma), .axi_resp_o_bfm(resp_bfm),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    dma = '0;
    bfm = '0;
    resp_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    arb_mode_i = 2'($urandom);
    dma = {$urandom, $urandom, $urandom, $urandom};
    bfm = {$urandom, $urandom, $urandom, $urandom};
    resp_i = {$urandom, $urandom};
    tick();
    @(negedge clk_i);
    checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (req_o !== '0) begin failures++; $display("FAIL reset_req_o got=%h exp=0", req_o); end
    checks++; if (resp_dma !== '0) begin failures++; $display("FAIL reset_resp_dma got=%h exp=0", resp_dma); end
    checks++; if (resp_bfm !== '0) begin failures++; $display("FAIL reset_resp_bfm got=%h exp=0", resp_bfm); end
    tick();
    rst_i = 1'b0;
    clear_inputs();
  endtask

  task automatic test_rr_tie();
    logic [31:0] rdata;
    do_reset();
    arb_mode_i = 2'b00;
    dma.ar_valid = 1'b1; dma.ar_addr = 32'h0000_1000;
    bfm.ar_valid = 1'b1; bfm.ar_addr = 32'h0000_2000;
    resp_i.ar_ready = 1'b1;
    @(negedge clk_i);
    checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL rr_first_cycle_grant got=%b exp=00", grant_o); end
    tick();
    @(negedge clk_i);
    checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL rr_dma_first got=%b exp=01", grant_o); end
    checks++; if (req_o.ar_valid !== 1'b1 || req_o.ar_addr !== 32'h0000_1000) begin
      failures++; $display("FAIL rr_dma_ar_fwd got=%b/%h exp=1/00001000", req_o.ar_valid, req_o.ar_addr); end
    tick();
    rdata = $urandom;
    dma.ar_valid = 1'b0; resp_i.ar_ready = 1'b0;
    resp_i.r_valid = 1'b1; resp_i.r_last = 1'b1; resp_i.r_data = rdata; dma.r_ready = 1'b1;
    @(negedge clk_i);
    checks++; if (resp_dma.r_valid !== 1'b1 || resp_dma.r_data !== rdata) begin
      failures++; $display("FAIL rr_dma_r_fwd got=%b/%h exp=1/%h", resp_dma.r_valid, resp_dma.r_data, rdata); end
    checks++; if (resp_bfm !== '0) begin failures++; $display("FAIL rr_bfm_resp_zero got=%h exp=0", resp_bfm); end
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL rr_busy_outstanding got=%b exp=1", busy_o); end
    tick();
    resp_i.r_valid = 1'b0; resp_i.r_last = 1'b0; dma.r_ready = 1'b0;
    @(negedge clk_i);
    checks++; if (grant_o !== 2'b01 || busy_o !== 1'b0) begin
      failures++; $display("FAIL rr_release_cycle got=%b/%b exp=01/0", grant_o, busy_o); end
    tick();
    @(negedge clk_i);
    checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL rr_idle_gap got=%b exp=00", grant_o); end
    tick();
    @(negedge clk_i);
    checks++; if (grant_o !== 2'b10 || req_o.ar_addr !== 32'h0000_2000) begin
      failures++; $display("FAIL rr_bfm_second got=%b/%h exp=10/00002000", grant_o, req_o.ar_addr); end
    clear_inputs();
  endtask

  task automatic test_fixed_prio_write();
    do_reset();
    arb_mode_i = 2'b11;
    bfm.aw_valid = 1'b1; bfm.aw_len = 8'd3;
    resp_i.aw_ready = 1'b1; resp_i.w_ready = 1'b1;
    tick();
    @(negedge clk_i);
    checks++; if (grant_o !== 2'b10) begin failures++; $display("FAIL fp_bfm_grant got=%b exp=10", grant_o); end
    tick();
    bfm.aw_valid = 1'b0;
    for (int beat = 0; beat < 4; beat++) begin
      bfm.w_valid = 1'b1; bfm.w_last = (beat == 3); bfm.w_data = $urandom;
      if (beat == 1) dma.aw_valid = 1'b1;
      @(negedge clk_i);
      checks++; if (grant_o !== 2'b10 || req_o.w_data !== bfm.w_data) begin
        failures++; $display("FAIL fp_w_beat%0d got=%b/%h exp=10/%h", beat, grant_o, req_o.w_data, bfm.w_data); end
      tick();
    end
    bfm.w_valid = 1'b0; bfm.w_last = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checks++; if (grant_o !== 2'b10 || busy_o !== 1'b1) begin
        failures++; $display("FAIL fp_wait_b%0d got=%b/%b exp=10/1", i, grant_o, busy_o); end
      tick();
    end
    resp_i.b_valid = 1'b1; bfm.b_ready = 1'b1;
    @(negedge clk_i);
    checks++; if (grant_o !== 2'b10) begin failures++; $display("FAIL fp_b_cycle got=%b exp=10", grant_o); end
    tick();
    resp_i.b_valid = 1'b0; bfm.b_ready = 1'b0;
    @(negedge clk_i);
    checks++; if (grant_o !== 2'b10 || busy_o !== 1'b0) begin
      failures++; $display("FAIL fp_release got=%b/%b exp=10/0", grant_o, busy_o); end
    tick();
    @(negedge clk_i);
    checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL fp_idle got=%b exp=00", grant_o); end
    tick();
    @(negedge clk_i);
    checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL fp_dma_next got=%b exp=01", grant_o); end
    clear_inputs();
  endtask

  task automatic test_ar_limit();
    do_reset();
    arb_mode_i = 2'b01;
    dma.ar_valid = 1'b1; resp_i.ar_ready = 1'b1;
    tick();
    for (int i = 0; i < MAX; i++) begin
      @(negedge clk_i);
      checks++; if (resp_dma.ar_ready !== 1'b1) begin
        failures++; $display("FAIL lim_ar_ready_%0d got=%b exp=1", i, resp_dma.ar_ready); end
      tick();
    end
    @(negedge clk_i);
    checks++; if (resp_dma.ar_ready !== 1'b0 || req_o.ar_valid !== 1'b0) begin
      failures++; $display("FAIL lim_blocked got=%b/%b exp=0/0", resp_dma.ar_ready, req_o.ar_valid); end
    tick();
    resp_i.r_valid = 1'b1; resp_i.r_last = 1'b1; dma.r_ready = 1'b1;
    @(negedge clk_i);
    checks++; if (resp_dma.ar_ready !== 1'b0) begin
      failures++; $display("FAIL lim_blocked_during_r got=%b exp=0", resp_dma.ar_ready); end
    tick();
    resp_i.r_valid = 1'b0; resp_i.r_last = 1'b0;
    @(negedge clk_i);
    checks++; if (resp_dma.ar_ready !== 1'b1 || req_o.ar_valid !== 1'b1) begin
      failures++; $display("FAIL lim_unblocked got=%b/%b exp=1/1", resp_dma.ar_ready, req_o.ar_valid); end
    clear_inputs();
  endtask

  task automatic test_same_cycle();
    do_reset();
    arb_mode_i = 2'b01;
    dma.ar_valid = 1'b1; resp_i.ar_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    resp_i.r_valid = 1'b1; resp_i.r_last = 1'b1; dma.r_ready = 1'b1;
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL same_busy got=%b exp=1", busy_o); end
    tick();
    dma.ar_valid = 1'b0; resp_i.ar_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL same_drain%0d got=%b exp=1", i, busy_o); end
      tick();
    end
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL same_drained got=%b exp=0", busy_o); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    arb_mode_i = 2'b01;
    dma.aw_valid = 1'b1; resp_i.aw_ready = 1'b1; resp_i.b_valid = 1'b1;
    tick();
    tick();
    tick();
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy_o); end
    tick();
    @(negedge clk_i);
    checks++; if (grant_o !== 2'b00 || busy_o !== 1'b0) begin
      failures++; $display("FAIL mid_after_rst got=%b/%b exp=00/0", grant_o, busy_o); end
    checks++; if (req_o !== '0 || resp_dma !== '0 || resp_bfm !== '0) begin
      failures++; $display("FAIL mid_outputs got=%h/%h/%h exp=0", req_o, resp_dma, resp_bfm); end
    rst_i = 1'b0;
    clear_inputs();
    tick();
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0 || grant_o !== 2'b00) begin
      failures++; $display("FAIL mid_counters_cleared got=%b/%b exp=0/00", busy_o, grant_o); end
  endtask

  task automatic test_mode_switch();
    do_reset();
    arb_mode_i = 2'b10;
    dma.aw_valid = 1'b1; resp_i.aw_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checks++; if (grant_o !== 2'b00 || resp_dma.aw_ready !== 1'b0) begin
        failures++; $display("FAIL ms_no_grant%0d got=%b/%b exp=00/0", i, grant_o, resp_dma.aw_ready); end
      tick();
    end
    arb_mode_i = 2'b01;
    @(negedge clk_i);
    checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL ms_switch_cycle got=%b exp=00", grant_o); end
    tick();
    @(negedge clk_i);
    checks++; if (grant_o !== 2'b01 || resp_dma.aw_ready !== 1'b1) begin
      failures++; $display("FAIL ms_dma_granted got=%b/%b exp=01/1", grant_o, resp_dma.aw_ready); end
    clear_inputs();
  endtask

  // Model: owner 0 none, 1 DMA, 2 BFM; counts are plain outstanding-burst tallies.
  function automatic int pick_owner(logic [1:0] mode, bit d, bit b, int last);
    case (mode)
      2'b01:   return d ? 1 : 0;
      2'b10:   return b ? 2 : 0;
      2'b11:   return d ? 1 : (b ? 2 : 0);
      default: begin
        if (d && b) return (last == 1) ? 2 : 1;
        return d ? 1 : (b ? 2 : 0);
      end
    endcase
  endfunction

  function automatic int tally(int c, bit up, bit down);
    if (up && down) return c;
    if (up && c < MAX) return c + 1;
    if (down && c > 0) return c - 1;
    return c;
  endfunction

  function automatic axi_req_t rand_req();
    axi_req_t r;
    r = {$urandom, $urandom, $urandom, $urandom};
    r.aw_valid = ($urandom_range(0, 6) == 0);
    r.w_valid  = ($urandom_range(0, 4) < 2);
    r.ar_valid = ($urandom_range(0, 6) == 0);
    r.b_ready  = ($urandom_range(0, 3) != 0);
    r.r_ready  = ($urandom_range(0, 3) != 0);
    return r;
  endfunction

  task automatic test_random();
    int owner, last, n_aw, n_w, n_ar;
    axi_req_t  e_req, own;
    axi_resp_t e_dma, e_bfm, gated;
    logic [1:0] e_grant;
    bit d_req, b_req;
    do_reset();
    owner = 0; last = 2; n_aw = 0; n_w = 0; n_ar = 0;
    arb_mode_i = 2'b00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 15) == 0) arb_mode_i = 2'($urandom);
      rst_i = ($urandom_range(0, 299) == 0);
      dma = rand_req();
      bfm = rand_req();
      resp_i = {$urandom, $urandom};
      resp_i.aw_ready = $urandom_range(0, 1);
      resp_i.w_ready  = ($urandom_range(0, 3) != 0);
      resp_i.ar_ready = $urandom_range(0, 1);
      resp_i.b_valid  = $urandom_range(0, 1);
      resp_i.r_valid  = $urandom_range(0, 1);
      @(negedge clk_i);
      own = (owner == 2) ? bfm : dma;
      gated = resp_i;
      gated.aw_ready = resp_i.aw_ready && (n_aw < MAX);
      gated.ar_ready = resp_i.ar_ready && (n_ar < MAX);
      e_req = '0; e_dma = '0; e_bfm = '0;
      if (owner != 0) begin
        e_req = own;
        e_req.aw_valid = own.aw_valid && (n_aw < MAX);
        e_req.ar_valid = own.ar_valid && (n_ar < MAX);
        if (owner == 1) e_dma = gated; else e_bfm = gated;
      end
      e_grant = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
      checks++; if (grant_o !== e_grant) begin failures++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, grant_o, e_grant); end
      checks++; if (busy_o !== (n_aw + n_w + n_ar != 0)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy_o, (n_aw + n_w + n_ar != 0)); end
      checks++; if (req_o !== e_req) begin failures++; $display("FAIL rnd_req_o cyc=%0d got=%h exp=%h", cyc, req_o, e_req); end
      checks++; if (resp_dma !== e_dma) begin failures++; $display("FAIL rnd_resp_dma cyc=%0d got=%h exp=%h", cyc, resp_dma, e_dma); end
      checks++; if (resp_bfm !== e_bfm) begin failures++; $display("FAIL rnd_resp_bfm cyc=%0d got=%h exp=%h", cyc, resp_bfm, e_bfm); end
      if (rst_i) begin
        owner = 0; last = 2; n_aw = 0; n_w = 0; n_ar = 0;
      end else begin
        d_req = dma.aw_valid || dma.w_valid || dma.ar_valid;
        b_req = bfm.aw_valid || bfm.w_valid || bfm.ar_valid;
        if (owner == 0) begin
          owner = pick_owner(arb_mode_i, d_req, b_req, last);
        end else if (n_aw == 0 && n_w == 0 && n_ar == 0 && !((owner == 1) ? d_req : b_req)) begin
          last = owner;
          owner = 0;
        end
        n_w  = tally(n_w, e_req.aw_valid && resp_i.aw_ready, e_req.w_valid && e_req.w_last && resp_i.w_ready);
        n_aw = tally(n_aw, e_req.aw_valid && resp_i.aw_ready, resp_i.b_valid && e_req.b_ready);
        n_ar = tally(n_ar, e_req.ar_valid && resp_i.ar_ready, resp_i.r_valid && resp_i.r_last && e_req.r_ready);
      end
      tick();
    end
    rst_i = 1'b0;
    clear_inputs();
  endtask

  initial begin
    rst_i = 1'b1;
    arb_mode_i = 2'b00;
    clear_inputs();
    test_reset();
    test_rr_tie();
    test_fixed_prio_write();
    test_ar_limit();
    test_same_cycle();
    test_reset_mid();
    test_mode_switch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_master_arbiter.md
AXI_MASTER_ARBITER -- requirements
Module: axi_master_arbiter

Interface
REQ-001 SHALL have parameter MaxTxns, default 8: maximum outstanding AW bursts, and separately AR bursts, per grant.
REQ-002 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port arb_mode_i, input, 2: 00 round-robin, 01 DMA only, 10 BFM only, 11 fixed priority DMA.
REQ-005 SHALL have port axi_req_i_dma, input, axi_req_t: DMA master request.
REQ-006 SHALL have port axi_req_i_bfm, input, axi_req_t: BFM master request.
REQ-007 SHALL have port axi_resp_i, input, axi_resp_t: slave response.
REQ-008 SHALL have port axi_req_o, output, axi_req_t: request forwarded to the slave.
REQ-009 SHALL have port axi_resp_o_dma, output, axi_resp_t: response to DMA.
REQ-010 SHALL have port axi_resp_o_bfm, output, axi_resp_t: response to BFM.
REQ-011 SHALL have port grant_o, output, 2: one-hot owner, bit0 DMA, bit1 BFM; 00 when idle.
REQ-012 SHALL have port busy_o, output, 1: high when any outstanding counter is nonzero.

Function
REQ-013 SHALL implement FSM states IDLE, GNT_DMA, GNT_BFM.
REQ-014 SHALL treat a master as requesting when its aw_valid or ar_valid or w_valid is high.
REQ-015 In IDLE, SHALL select the next owner, registered; forwarding starts the cycle after the request is first seen (1-cycle arbitration latency).
REQ-016 Selection by mode: 01 grants DMA only; 10 grants BFM only; 11 grants DMA when requesting, else BFM; 00 alternates on simultaneous requests using a last_owner register.
REQ-017 In IDLE, axi_req_o SHALL be all-zero and both response outputs all-zero.
REQ-018 In GNT_x, SHALL drive axi_req_o with master x's request and drive x's response output with axi_resp_i; the other master's response output SHALL be all-zero.
REQ-019 SHALL keep aw_cnt: +1 on an AW handshake to the slave, −1 on a B handshake; both in the same cycle leaves it unchanged.
REQ-020 SHALL keep w_cnt: +1 on an AW handshake, −1 on a W handshake with w.last; both in the same cycle leaves it unchanged.
REQ-021 SHALL keep ar_cnt: +1 on an AR handshake, −1 on an R handshake with r.last; both in the same cycle leaves it unchanged.
REQ-022 Counters SHALL be $clog2(MaxTxns+1) bits wide.
REQ-023 When aw_cnt == MaxTxns (registered value), SHALL force aw_valid to the slave low and aw_ready to the owner low; ar_cnt/AR SHALL be handled the same way.
REQ-024 SHALL never let a counter overflow or underflow.
REQ-025 Release: SHALL return GNT_x to IDLE when all counters are 0 and the owner's aw_valid, w_valid and ar_valid are all low in that cycle; SHALL update last_owner on release.
REQ-026 The grant SHALL never change while any counter is nonzero or an owner valid is pending.
REQ-027 A change of arb_mode_i while granted SHALL not preempt; it SHALL apply at the next IDLE selection.
REQ-028 busy_o SHALL be the OR of counters-nonzero; grant_o SHALL decode the FSM state.

Reset
REQ-029 rst_i high SHALL set state IDLE, all counters 0, last_owner = BFM (DMA wins the first round-robin tie), grant_o = 00, busy_o = 0, and all outputs all-zero.
REQ-030 Reset mid-transaction SHALL discard all outstanding state; orphaned slave responses are not tracked.

Structure
REQ-031 The arb_mode encoding (typedef enum) and the FSM state enum SHALL live in venus_soc_pkg; axi_req_t and axi_resp_t SHALL come from that package.
REQ-032 The three counters SHALL use one sub-module, axi_txn_counter (inc, dec, at_max, zero flags), instantiated three times.

Verification
REQ-033 Mode 00, both masters assert ar_valid in the same cycle after reset -> DMA granted first; after its single-beat R last, BFM granted; grant_o 01 then 10.
REQ-034 Mode 11, BFM holds a 4-beat write with DMA requesting midway -> grant stays 10 until B handshake, then switches to 01 on the next arbitration.
REQ-035 MaxTxns=8, DMA issues 9 AR with slave withholding R -> 9th AR blocked (ar_ready to DMA low) while ar_cnt == 8; the first R last unblocks it.
REQ-036 AR handshake and R last in the same cycle at ar_cnt=3 -> ar_cnt stays 3; busy_o remains 1.
REQ-037 rst_i asserted with aw_cnt=2 -> next cycle state IDLE, counters 0, grant_o 00, all outputs zero.
REQ-038 Mode 10 with only DMA requesting -> no grant and DMA ready stays 0; switching to mode 01 -> DMA granted one cycle after the next IDLE evaluation.
